tff_sync_counter: RTL and testbench
===================================

TFF_SYNC_COUNTER -- requirements
Module: tff_sync_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; every register updates on the rising edge only.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: en  input  1  count enable; one count step per clk edge while high.
REQ-005 Port: up_dn  input  1  direction select; 1 = count up, 0 = count down.
REQ-006 Port: load  input  1  synchronous parallel load strobe.
REQ-007 Port: load_val  input  WIDTH  value written to the counter when load is high.
REQ-008 Port: mod_max  input  WIDTH  terminal value; the count range is 0..mod_max inclusive.
REQ-009 Port: Q  output  WIDTH  registered count value.
REQ-010 Port: Q_bar  output  WIDTH  bitwise complement of Q.
REQ-011 Port: tc  output  1  terminal count, combinational: (up_dn=1 and Q=mod_max) or (up_dn=0 and Q=0).
REQ-012 Port: wrap  output  1  registered one-cycle pulse, asserted the cycle after the counter wraps.

Function
REQ-013 Update priority per edge SHALL be rst > load > en > hold.
REQ-014 Up step: if Q=mod_max then Q<=0 and wrap<=1, else Q<=Q+1 and wrap<=0.
REQ-015 Down step: if Q=0 then Q<=mod_max and wrap<=1, else Q<=Q-1 and wrap<=0.
REQ-016 Load: Q<=min(load_val, mod_max) and wrap<=0, regardless of en and up_dn.
REQ-017 Hold (en=0, load=0): Q is unchanged and wrap<=0.
REQ-018 Count latency: Q SHALL reflect a step or load one clk edge after it is sampled; wrap SHALL assert on that same edge.
REQ-019 If Q>mod_max (mod_max lowered at run time), the next up step SHALL give Q<=0 with wrap<=1, and the next down step SHALL give Q<=mod_max with wrap<=0.
REQ-020 mod_max=0: Q SHALL stay 0, and wrap SHALL assert on every enabled edge.
REQ-021 Q_bar SHALL equal ~Q on every cycle, including during and after reset.
REQ-022 Each Q bit SHALL be held in a T-type storage cell, with the toggle input T[i] = Q[i] XOR next_Q[i]; no bit SHALL be written directly with D.
REQ-023 A direction change SHALL take effect on the same edge on which the new up_dn value is sampled, with no idle cycle.

Reset
REQ-024 When rst is sampled high: Q<=0, Q_bar=all ones, and wrap<=0.
REQ-025 rst asserted mid-count SHALL override load and en on that edge, and no wrap pulse SHALL be produced.
REQ-026 The first count step SHALL occur on the first edge on which rst=0 and en=1.

Structure
REQ-027 A shared package, tff_pkg, SHALL hold the direction constants DIR_UP=1 and DIR_DN=0 and the default-width constant TFF_WIDTH=4.
REQ-028 The storage cell SHALL be a separate sub-module, t_cell: ports clk, rst, T, Q, Q_bar; synchronous active-high reset to Q=0; Q toggles when T=1.
REQ-029 tff_sync_counter SHALL instantiate WIDTH copies of t_cell, plus the next-state logic, the tc logic and the wrap register.

Verification
REQ-030 Reset: assert rst for 2 edges while en=1 and load=1 -> Q=0, Q_bar=4'hF, wrap=0 throughout.
REQ-031 Up wrap: WIDTH=4, mod_max=9, up_dn=1, en=1 for 12 edges from reset -> Q runs 1..9,0,1,2; tc=1 only while Q=9; wrap=1 only on the edge where Q goes 9->0.
REQ-032 Down wrap with direction change: load_val=2, mod_max=5; load, then en=1 with up_dn=0 for 4 edges -> Q=1,0,5,4 with wrap on 0->5; then set up_dn=1 -> next edge Q=5.
REQ-033 Load clamp and priority: mod_max=6, load_val=4'hC, load=1 and en=1 together -> Q=6, wrap=0; then load=0, en=0 for 3 edges -> Q holds at 6.
REQ-034 Boundary cases:
- mod_max=0, en=1 for 3 edges -> Q=0 and wrap=1 on each edge.
- With Q=8, lower mod_max to 3 and take an up step -> Q=0, wrap=1.
REQ-035 Mid-count reset: at Q=7 counting up, assert rst for one edge -> Q=0, wrap=0; deassert rst -> counting resumes with Q=1.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared constants and step-kind encoding for the T-flip-flop synchronous counter.
package tff_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam int   TFF_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DN   = 2'd3
    } tff_op_e;

endpackage : tff_pkg

// File: rtl/t_cell.sv
// Single T-type storage cell: synchronous active-high reset to 0, toggles when T is high.
module t_cell (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic Q,
    output logic Q_bar
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (T) begin
            r_q <= ~r_q;
        end
    end

    assign Q     = r_q;
    assign Q_bar = ~r_q;

endmodule : t_cell

// File: rtl/tff_sync_counter.sv
// Modulo up/down counter built from T cells; next value is computed in binary and
// turned into per-bit toggles, with a registered wrap pulse and combinational tc.
module tff_sync_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_toggle;
    logic             w_wrap_next;
    tff_op_e          w_op;
    logic             r_wrap;

    always_comb begin
        w_op = OP_HOLD;
        if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            w_op = (up_dn == DIR_UP) ? OP_UP : OP_DN;
        end
    end

    // Out-of-range counts (mod_max lowered at run time) wrap to 0 going up but
    // snap to mod_max without a wrap pulse going down.
    always_comb begin
        w_q_next    = w_q;
        w_wrap_next = 1'b0;
        case (w_op)
            OP_LOAD: begin
                w_q_next = (load_val > mod_max) ? mod_max : load_val;
            end
            OP_UP: begin
                if (w_q >= mod_max) begin
                    w_q_next    = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_q_next = w_q + ONE;
                end
            end
            OP_DN: begin
                if (w_q == '0) begin
                    w_q_next    = mod_max;
                    w_wrap_next = 1'b1;
                end else if (w_q > mod_max) begin
                    w_q_next = mod_max;
                end else begin
                    w_q_next = w_q - ONE;
                end
            end
            default: begin
                w_q_next = w_q;
            end
        endcase
    end

    assign w_toggle = w_q ^ w_q_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            t_cell u_cell (
                .clk   (clk),
                .rst   (rst),
                .T     (w_toggle[gi]),
                .Q     (w_q[gi]),
                .Q_bar (w_q_bar[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign Q     = w_q;
    assign Q_bar = w_q_bar;
    assign wrap  = r_wrap;
    assign tc    = (up_dn == DIR_UP) ? (w_q == mod_max) : (w_q == '0);

endmodule : tff_sync_counter

// File: tb/tb_tff_sync_counter.sv
// Directed scenarios followed by random steps, each checked against an integer model of the counter rules.
module tb_tff_sync_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] mod_max = '0;
    logic [W-1:0] Q;
    logic [W-1:0] Q_bar;
    logic         tc;
    logic         wrap;

    int n_pass   = 0;
    int n_checks = 0;
    int n_step   = 0;
    int q_m      = 0;
    int w_m      = 0;

    tff_sync_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .mod_max  (mod_max),
        .Q        (Q),
        .Q_bar    (Q_bar),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s step %0d: observed %0h expected %0h", tag, n_step, act, exp);
    endtask

    // Apply one set of inputs, advance the model, take one edge, then check all outputs.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input int lv, input int mm);
        int   exp_tc;
        int   qbar_exp;
        rst      = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = W'(lv);
        mod_max  = W'(mm);
        if (r) begin
            q_m = 0; w_m = 0;
        end else if (l) begin
            q_m = (lv < mm) ? lv : mm; w_m = 0;
        end else if (e && u) begin
            if (q_m >= mm) begin q_m = 0; w_m = 1; end
            else begin q_m = q_m + 1; w_m = 0; end
        end else if (e) begin
            if (q_m == 0) begin q_m = mm; w_m = 1; end
            else if (q_m > mm) begin q_m = mm; w_m = 0; end
            else begin q_m = q_m - 1; w_m = 0; end
        end else begin
            w_m = 0;
        end
        @(posedge clk);
        #1;
        n_step++;
        exp_tc   = u ? int'(q_m == mm) : int'(q_m == 0);
        qbar_exp = (2**W - 1) - q_m;
        $display("step %0d rst=%0b en=%0b up=%0b ld=%0b lv=%0d mm=%0d -> Q=%0d wrap=%0b tc=%0b",
                 n_step, r, e, u, l, lv, mm, Q, wrap, tc);
        chk("Q", 32'(Q), 32'(q_m));
        chk("Q_bar", 32'(Q_bar), 32'(qbar_exp));
        chk("wrap", 32'(wrap), 32'(w_m));
        chk("tc", 32'(tc), 32'(exp_tc));
    endtask

    initial begin
        // Reset held with load and en asserted
        step(1, 1, 1, 1, 5, 9);
        step(1, 1, 1, 1, 5, 9);
        // Up count with wrap at 9
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 9);
        // Load 2, count down through wrap, then reverse direction
        step(0, 0, 0, 1, 2, 5);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 5);
        step(0, 1, 1, 0, 0, 5);
        // Load clamp beats enable, then hold
        step(0, 1, 1, 1, 12, 6);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 6);
        // mod_max = 0
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Lower mod_max below the current count
        step(0, 0, 1, 1, 8, 15);
        step(0, 1, 1, 0, 0, 3);
        step(0, 0, 1, 1, 8, 15);
        step(0, 1, 0, 0, 0, 3);
        // Mid-count reset
        step(1, 0, 1, 0, 0, 15);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 15);
        step(1, 1, 1, 0, 0, 15);
        step(0, 1, 1, 0, 0, 15);
        // Random traffic
        begin
            int mm_r;
            mm_r = 9;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 7) == 0)
                    mm_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                                       : int'($urandom_range(0, 15));
                step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, 15)), mm_r);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tff_sync_counter
